// File: rtl/nand_op_arbiter.sv
// Round-robin arbiter that shares one NAND command engine between the page
// read, page program and block erase requesters. Launches the granted
// operation, holds the grant until the engine reports done, and aborts
// through a watchdog if done never arrives.
module nand_op_arbiter #(
    parameter int          ADDR_W      = 24,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic              req_er,
    input  logic [ADDR_W-1:0] addr_rd,
    input  logic [ADDR_W-1:0] addr_wr,
    input  logic [ADDR_W-1:0] addr_er,
    input  logic              op_done,
    input  logic              op_fail,
    output logic [2:0]        grant,
    output logic              op_start,
    output logic [1:0]        op_code,
    output logic [ADDR_W-1:0] op_addr,
    output logic              busy,
    output logic [2:0]        fin_ok,
    output logic [2:0]        fin_err,
    output logic              timeout_err,
    output logic [2:0]        arb_state
);

    localparam int unsigned         TMR_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_TOUT  = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         last_grant;
    logic [TMR_W-1:0]   timer;
    logic               fail_q;
    logic [2:0]         req_vec;
    logic [2:0]         win;
    logic [1:0]         win_code;
    logic [ADDR_W-1:0]  win_addr;

    assign req_vec = {req_er, req_wr, req_rd};

    // Round-robin pick: scan rd->wr->er starting just after the last grant.
    always_comb begin
        win = '0;
        case (last_grant)
            3'b001: begin
                if (req_wr)      win = 3'b010;
                else if (req_er) win = 3'b100;
                else if (req_rd) win = 3'b001;
            end
            3'b010: begin
                if (req_er)      win = 3'b100;
                else if (req_rd) win = 3'b001;
                else if (req_wr) win = 3'b010;
            end
            default: begin
                if (req_rd)      win = 3'b001;
                else if (req_wr) win = 3'b010;
                else if (req_er) win = 3'b100;
            end
        endcase
    end

    // Operation code and row address belonging to the round-robin winner.
    always_comb begin
        win_code = 2'd0;
        win_addr = '0;
        if (win[0]) begin
            win_code = 2'd1;
            win_addr = addr_rd;
        end else if (win[1]) begin
            win_code = 2'd2;
            win_addr = addr_wr;
        end else if (win[2]) begin
            win_code = 2'd3;
            win_addr = addr_er;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; op_done takes precedence over the watchdog.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = (|req_vec) ? S_ARB : S_IDLE;
            S_ARB:   state_nxt = (|win) ? S_START : S_IDLE;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (op_done)                state_nxt = S_DONE;
                else if (timer == TMR_LAST) state_nxt = S_TOUT;
                else                        state_nxt = S_WAIT;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_TOUT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant/command latches, round-robin pointer, watchdog timer and fail latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            op_code    <= '0;
            op_addr    <= '0;
            last_grant <= 3'b100;
            timer      <= '0;
            fail_q     <= 1'b0;
        end else begin
            case (state)
                S_ARB: begin
                    if (|win) begin
                        grant   <= win;
                        op_code <= win_code;
                        op_addr <= win_addr;
                    end
                end
                S_START: timer <= '0;
                S_WAIT: begin
                    if (timer != '1) timer <= timer + TMR_W'(1);
                    if (op_done)     fail_q <= op_fail;
                end
                S_DONE, S_TOUT: begin
                    last_grant <= grant;
                    grant      <= '0;
                    op_code    <= '0;
                end
                default: ;
            endcase
        end
    end

    // State-decoded outputs: launch pulse, completion pulses, status.
    always_comb begin
        op_start    = 1'b0;
        fin_ok      = '0;
        fin_err     = '0;
        timeout_err = 1'b0;
        busy        = (state != S_IDLE);
        arb_state   = state;
        case (state)
            S_START: op_start = 1'b1;
            S_DONE: begin
                if (fail_q) fin_err = grant;
                else        fin_ok  = grant;
            end
            S_TOUT: begin
                timeout_err = 1'b1;
                fin_err     = grant;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nand_op_arbiter.sv
// Directed bench for nand_op_arbiter: latency, round-robin order, fail and
// timeout completion, watchdog boundary, and reset abort.
module tb_nand_op_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr, req_er;
    logic [23:0] addr_rd, addr_wr, addr_er;
    logic        op_done, op_fail;
    logic [2:0]  grant;
    logic        op_start;
    logic [1:0]  op_code;
    logic [23:0] op_addr;
    logic        busy;
    logic [2:0]  fin_ok, fin_err;
    logic        timeout_err;
    logic [2:0]  arb_state;

    int checks   = 0;
    int failures = 0;

    nand_op_arbiter #(.ADDR_W(24), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr), .req_er(req_er),
        .addr_rd(addr_rd), .addr_wr(addr_wr), .addr_er(addr_er),
        .op_done(op_done), .op_fail(op_fail),
        .grant(grant), .op_start(op_start), .op_code(op_code),
        .op_addr(op_addr), .busy(busy), .fin_ok(fin_ok), .fin_err(fin_err),
        .timeout_err(timeout_err), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation from IDLE with the request(s) already applied.
    task automatic serve(input string tag, input logic [2:0] g, input logic [1:0] code,
                         input logic [23:0] addr, input int wait_cycles, input logic fail);
        tick();
        check({tag, "/arb_state"}, 32'(arb_state), 1);
        tick();
        check({tag, "/grant"}, 32'(grant), 32'(g));
        check({tag, "/onehot"}, 32'($onehot(grant)), 1);
        check({tag, "/op_code"}, 32'(op_code), 32'(code));
        check({tag, "/op_addr"}, 32'(op_addr), 32'(addr));
        check({tag, "/op_start"}, 32'(op_start), 1);
        tick();
        check({tag, "/wait_state"}, 32'(arb_state), 3);
        check({tag, "/start_drop"}, 32'(op_start), 0);
        for (int i = 1; i < wait_cycles; i++) tick();
        check({tag, "/still_wait"}, 32'(arb_state), 3);
        op_done = 1'b1;
        op_fail = fail;
        tick();
        op_done = 1'b0;
        op_fail = 1'b0;
        check({tag, "/done_state"}, 32'(arb_state), 4);
        check({tag, "/fin_ok"}, 32'(fin_ok), fail ? 32'd0 : 32'(g));
        check({tag, "/fin_err"}, 32'(fin_err), fail ? 32'(g) : 32'd0);
        check({tag, "/no_timeout"}, 32'(timeout_err), 0);
        tick();
        check({tag, "/idle"}, 32'(arb_state), 0);
        check({tag, "/grant_clr"}, 32'(grant), 0);
        check({tag, "/code_clr"}, 32'(op_code), 0);
        check({tag, "/fin_clr"}, 32'({fin_ok, fin_err}), 0);
    endtask

    initial begin
        rst = 1'b1;
        req_rd = 1'b0; req_wr = 1'b0; req_er = 1'b0;
        addr_rd = '0; addr_wr = '0; addr_er = '0;
        op_done = 1'b0; op_fail = 1'b0;
        tick();
        tick();
        check("rst/grant", 32'(grant), 0);
        check("rst/op_start", 32'(op_start), 0);
        check("rst/op_code", 32'(op_code), 0);
        check("rst/op_addr", 32'(op_addr), 0);
        check("rst/busy", 32'(busy), 0);
        check("rst/fin", 32'({fin_ok, fin_err, timeout_err}), 0);
        check("rst/state", 32'(arb_state), 0);
        rst = 1'b0;

        // Single read: latency, latch stability, pass completion.
        req_rd = 1'b1;
        addr_rd = 24'h000120;
        tick();
        check("t1/arb", 32'(arb_state), 1);
        check("t1/arb_busy", 32'(busy), 1);
        check("t1/arb_nogrant", 32'(grant), 0);
        tick();
        check("t1/grant", 32'(grant), 32'b001);
        check("t1/op_code", 32'(op_code), 1);
        check("t1/op_addr", 32'(op_addr), 32'h000120);
        check("t1/op_start", 32'(op_start), 1);
        req_rd = 1'b0;
        addr_rd = 24'hABCDEF;
        tick();
        check("t1/wait", 32'(arb_state), 3);
        check("t1/start_pulse", 32'(op_start), 0);
        check("t1/addr_hold", 32'(op_addr), 32'h000120);
        check("t1/grant_hold", 32'(grant), 32'b001);
        tick();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        check("t1/fin_ok", 32'(fin_ok), 32'b001);
        check("t1/fin_err", 32'(fin_err), 0);
        tick();
        check("t1/idle", 32'(arb_state), 0);
        check("t1/grant_clr", 32'(grant), 0);
        check("t1/fin_clr", 32'(fin_ok), 0);

        // Stray done while idle, and a request withdrawn during ARB.
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        check("stray_done/state", 32'(arb_state), 0);
        check("stray_done/fin", 32'({fin_ok, fin_err}), 0);
        req_wr = 1'b1;
        tick();
        check("drop/arb", 32'(arb_state), 1);
        req_wr = 1'b0;
        tick();
        check("drop/idle", 32'(arb_state), 0);
        check("drop/grant", 32'(grant), 0);
        check("drop/op_start", 32'(op_start), 0);

        // Round-robin with all requests held, starting from reset pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_rd = 1'b1; req_wr = 1'b1; req_er = 1'b1;
        addr_rd = 24'h000111; addr_wr = 24'h000222; addr_er = 24'h000333;
        serve("rr1_rd", 3'b001, 2'd1, 24'h000111, 10, 1'b0);
        serve("rr2_wr", 3'b010, 2'd2, 24'h000222, 10, 1'b0);
        serve("rr3_er", 3'b100, 2'd3, 24'h000333, 10, 1'b0);
        serve("rr4_rd", 3'b001, 2'd1, 24'h000111, 10, 1'b0);
        req_rd = 1'b0; req_wr = 1'b0; req_er = 1'b0;

        // Erase fails, then a read passes (fail latch must not stick).
        req_er = 1'b1;
        serve("t3_er_fail", 3'b100, 2'd3, 24'h000333, 4, 1'b1);
        req_er = 1'b0;
        req_rd = 1'b1;
        serve("t3_rd_ok", 3'b001, 2'd1, 24'h000111, 2, 1'b0);
        req_rd = 1'b0;

        // Watchdog: no done, abort on the 16th WAIT cycle.
        req_wr = 1'b1;
        tick();
        tick();
        check("t4/grant", 32'(grant), 32'b010);
        tick();
        req_wr = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("t4/pre_tout_state", 32'(arb_state), 3);
        check("t4/pre_tout_err", 32'(timeout_err), 0);
        tick();
        check("t4/tout_state", 32'(arb_state), 5);
        check("t4/timeout_err", 32'(timeout_err), 1);
        check("t4/fin_err", 32'(fin_err), 32'b010);
        check("t4/fin_ok", 32'(fin_ok), 0);
        check("t4/busy", 32'(busy), 1);
        tick();
        check("t4/idle", 32'(arb_state), 0);
        check("t4/grant_clr", 32'(grant), 0);
        check("t4/tout_clr", 32'(timeout_err), 0);

        // Pointer now at wr: er beats rd.
        req_rd = 1'b1; req_er = 1'b1;
        serve("ptr_er", 3'b100, 2'd3, 24'h000333, 3, 1'b0);
        req_er = 1'b0;
        // Done on the 16th WAIT cycle wins over the watchdog.
        serve("t5_edge", 3'b001, 2'd1, 24'h000111, 16, 1'b0);
        req_rd = 1'b0;

        // Reset mid-WAIT aborts without a completion pulse.
        req_wr = 1'b1;
        tick();
        tick();
        check("t6/grant", 32'(grant), 32'b010);
        tick();
        tick();
        tick();
        check("t6/wait", 32'(arb_state), 3);
        rst = 1'b1;
        tick();
        check("t6/grant", 32'(grant), 0);
        check("t6/state", 32'(arb_state), 0);
        check("t6/outs", 32'({op_start, op_code, busy, fin_ok, fin_err, timeout_err}), 0);
        check("t6/op_addr", 32'(op_addr), 0);
        rst = 1'b0;
        req_rd = 1'b1; req_er = 1'b1;
        serve("t6_rd_first", 3'b001, 2'd1, 24'h000111, 2, 1'b0);
        req_rd = 1'b0; req_wr = 1'b0; req_er = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
